rtc_bcd_editor: RTL

Downstream companion of the menu FSM in the RTC controller. Keeps a shadow copy of the seven RTC time/date registers. Applies the menu's single-cycle Numup/Numdown strobes to the register selected by DIR using BCD arithmetic with per-field wrap-around, then issues one write transaction per edit to the RTC bus controller. Read data from the RTC refreshes the shadow registers, and the selected field is presented to the display path.

---
 rtl/rtc_bcd_editor.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/rtc_bcd_editor.sv
// +-----------------------------------------------------------------------------
// | rtc_bcd_editor: shadow RTC time/date registers with BCD up/down editing and
// | one bus write per edit. Optional macro WR_TIMEOUT_EN adds a write timeout.
// | Revision 1.0
// +-----------------------------------------------------------------------------
`default_nettype none

module rtc_bcd_editor #(
  parameter int TIMEOUT = 255
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [2:0] DIR,
  input  logic       Numup,
  input  logic       Numdown,
  input  logic       RD_VALID,
  input  logic [2:0] RD_ADDR,
  input  logic [7:0] RD_DATA,
  input  logic       WR_ACK,
  output logic       WR_REQ,
  output logic [2:0] WR_ADDR,
  output logic [7:0] WR_DATA,
  output logic [7:0] VALUE,
  output logic       BUSY,
  output logic       WR_DONE,
  output logic       WR_ERR
);

  typedef enum logic [0:0] {IDLE = 1'b0, WRITE = 1'b1} state_t;

  state_t     state_q, state_d;
  logic [7:0] shadow_q [8];
  logic [7:0] shadow_d [8];
  logic [2:0] wr_addr_q, wr_addr_d;
  logic [7:0] wr_data_q, wr_data_d;
  logic       wr_done_q, wr_done_d;
  logic       accept;
  logic [7:0] edit_val;

  function automatic logic [7:0] field_min(input logic [2:0] a);
    case (a)
      3'd4, 3'd5, 3'd6: field_min = 8'h01;
      default:          field_min = 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] field_max(input logic [2:0] a);
    case (a)
      3'd1, 3'd2: field_max = 8'h59;
      3'd3:       field_max = 8'h23;
      3'd4:       field_max = 8'h07;
      3'd5:       field_max = 8'h31;
      3'd6:       field_max = 8'h12;
      default:    field_max = 8'h99;
    endcase
  endfunction

  // Valid BCD bytes order the same way as their decimal values, so a plain
  // byte compare is a correct range check once both nibbles are <= 9.
  function automatic logic field_ok(input logic [7:0] v, input logic [2:0] a);
    field_ok = (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) &&
               (v >= field_min(a)) && (v <= field_max(a));
  endfunction

  function automatic logic [7:0] bcd_step(input logic [7:0] v, input logic [2:0] a,
                                          input logic up);
    if (up) begin
      if (!field_ok(v, a) || v == field_max(a)) bcd_step = field_min(a);
      else if (v[3:0] == 4'd9)                  bcd_step = {v[7:4] + 4'd1, 4'd0};
      else                                      bcd_step = v + 8'd1;
    end else begin
      if (!field_ok(v, a) || v == field_min(a)) bcd_step = field_max(a);
      else if (v[3:0] == 4'd0)                  bcd_step = {v[7:4] - 4'd1, 4'd9};
      else                                      bcd_step = v - 8'd1;
    end
  endfunction

  assign accept   = (state_q == IDLE) && (DIR != 3'd0) && (Numup ^ Numdown);
  assign edit_val = bcd_step(shadow_q[DIR], DIR, Numup);

`ifdef WR_TIMEOUT_EN
  logic [7:0] cnt_q, cnt_d;
  logic       wr_err_q, wr_err_d;
  logic       limit;
  assign limit = (cnt_q == 8'(TIMEOUT - 1));
`endif

  always_comb begin
    state_d   = state_q;
    shadow_d  = shadow_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    wr_done_d = 1'b0;
`ifdef WR_TIMEOUT_EN
    cnt_d     = cnt_q;
    wr_err_d  = wr_err_q;
`endif
    // An edit on the same address takes precedence over the read.
    if (RD_VALID && RD_ADDR != 3'd0 && !(accept && RD_ADDR == DIR))
      shadow_d[RD_ADDR] = RD_DATA;
    case (state_q)
      IDLE: begin
        if (accept) begin
          shadow_d[DIR] = edit_val;
          wr_addr_d     = DIR;
          wr_data_d     = edit_val;
          state_d       = WRITE;
`ifdef WR_TIMEOUT_EN
          cnt_d         = 8'd0;
          wr_err_d      = 1'b0;
`endif
        end
      end
      default: begin
        if (WR_ACK) begin
          state_d   = IDLE;
          wr_done_d = 1'b1;
        end
`ifdef WR_TIMEOUT_EN
        else if (limit) begin
          state_d  = IDLE;
          wr_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
`endif
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= IDLE;
      for (int i = 0; i < 8; i++) shadow_q[i] <= (i >= 4 && i <= 6) ? 8'h01 : 8'h00;
      wr_addr_q <= 3'd0;
      wr_data_q <= 8'h00;
      wr_done_q <= 1'b0;
`ifdef WR_TIMEOUT_EN
      cnt_q     <= 8'd0;
      wr_err_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      shadow_q  <= shadow_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      wr_done_q <= wr_done_d;
`ifdef WR_TIMEOUT_EN
      cnt_q     <= cnt_d;
      wr_err_q  <= wr_err_d;
`endif
    end
  end

  assign WR_REQ  = (state_q == WRITE);
  assign BUSY    = (state_q == WRITE);
  assign WR_ADDR = wr_addr_q;
  assign WR_DATA = wr_data_q;
  assign WR_DONE = wr_done_q;
  assign VALUE   = (DIR == 3'd0) ? 8'h00 : shadow_q[DIR];
`ifdef WR_TIMEOUT_EN
  assign WR_ERR  = wr_err_q;
`else
  assign WR_ERR  = 1'b0;
`endif

endmodule

`default_nettype wire
